fetch_unit: RTL

Instruction-fetch stage: owns the PC, drives the instruction-memory request/acknowledge handshake and produces the instruction word, PC+4 and the 2-bit load/hold/flush code that the IF/ID register consumes. Sits between instruction memory and IF/ID. Absorbs variable memory latency, ID-stage stalls and branch/jump redirects so that IF/ID only ever loads a correct, in-order instruction or a bubble.

---
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, runs the imem req/ack
// handshake and hands IF/ID an instruction, PC+4 and a load/hold/flush code.
//
// Ports:
//   clk, Reset        clock, synchronous active-high reset
//   stall             ID must hold its instruction this cycle
//   redirect(_pc)     taken branch/jump from ID (ignored while stall=1)
//   imem_req/addr     fetch request, held stable until imem_ack
//   imem_ack/data     one ack per request, data valid with ack
//   iiI, PCp4         instruction and fetch address + 4 to IF/ID
//   a10               IF/ID control: 0 load, 1 hold, 2 flush
//   perf_fetched/perf_bubble  load and bubble counters
//                     (present only when FETCH_PERF_EN is defined)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] iiI,
  output logic [31:0] PCp4,
  output logic [1:0]  a10
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubble
`endif
);

  localparam logic [1:0] CTL_LOAD  = 2'd0;
  localparam logic [1:0] CTL_HOLD  = 2'd1;
  localparam logic [1:0] CTL_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] hold_ins, hold_ins_d;
  logic [31:0] hold_pc, hold_pc_d;
  logic [31:0] drop_addr, drop_addr_d;

  logic [31:0] pc_p4;
  logic [31:0] hold_p4;
  logic        redir;

  assign pc_p4   = pc + 32'd4;
  assign hold_p4 = hold_pc + 32'd4;

  // ID only re-presents a redirect once it is no longer stalled.
  assign redir = redirect & ~stall;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      hold_ins  <= 32'd0;
      hold_pc   <= 32'd0;
      drop_addr <= 32'd0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      hold_ins  <= hold_ins_d;
      hold_pc   <= hold_pc_d;
      drop_addr <= drop_addr_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    hold_ins_d  = hold_ins;
    hold_pc_d   = hold_pc;
    drop_addr_d = drop_addr;
    imem_req    = 1'b0;
    imem_addr   = pc;
    a10         = CTL_FLUSH;
    iiI         = 32'd0;
    PCp4        = 32'd0;

    unique case (state)
      S_REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (imem_ack) begin
          unique case (1'b1)
            stall: begin
              // Park the word; memory is free again.
              hold_ins_d = imem_data;
              hold_pc_d  = pc;
              a10        = CTL_HOLD;
              state_d    = S_HOLD;
            end
            redirect: begin
              a10  = CTL_FLUSH;
              pc_d = redirect_pc;
            end
            default: begin
              a10  = CTL_LOAD;
              iiI  = imem_data;
              PCp4 = pc_p4;
              pc_d = pc_p4;
            end
          endcase
        end else if (redir) begin
          // Request in flight cannot be withdrawn: wait out its ack.
          drop_addr_d = pc;
          pc_d        = redirect_pc;
          a10         = CTL_FLUSH;
          state_d     = S_DROP;
        end else begin
          a10 = stall ? CTL_HOLD : CTL_FLUSH;
        end
      end

      S_HOLD: begin
        imem_req = 1'b0;
        iiI      = hold_ins;
        PCp4     = hold_p4;
        unique case (1'b1)
          stall: begin
            a10 = CTL_HOLD;
          end
          redirect: begin
            a10     = CTL_FLUSH;
            pc_d    = redirect_pc;
            state_d = S_REQ;
          end
          default: begin
            a10     = CTL_LOAD;
            pc_d    = hold_p4;
            state_d = S_REQ;
          end
        endcase
      end

      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr;
        a10       = stall ? CTL_HOLD : CTL_FLUSH;
        // Latest target wins; ack and redirect may coincide.
        if (redir) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    // Reset abandons any outstanding request and flushes IF/ID.
    if (Reset) begin
      imem_req = 1'b0;
      a10      = CTL_FLUSH;
      iiI      = 32'd0;
      PCp4     = 32'd0;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      perf_fetched <= 32'd0;
      perf_bubble  <= 32'd0;
    end else begin
      if (a10 == CTL_LOAD) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (a10 == CTL_FLUSH) begin
        perf_bubble <= perf_bubble + 32'd1;
      end
    end
  end
`endif

endmodule
